// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic package.
// Purpose: state encoding for the serial arithmetic FSMs and a constant
//          clog2 helper used to size slice counters.
// Contents: state_t (IDLE, RUN, DONE), function clog2.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) == 0, so callers clamp to at least one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// Purpose: groups the start handshake, operands and result signals.
// Ports (slave = subtractor side):
//   start, a, b, borrow_in, signed_mode : requester -> subtractor
//   ready, busy, done, diff, borrow_out, overflow, state : subtractor -> requester
// Handshake: a request is taken on a rising edge where start=1 and ready=1;
//   the operand signals only need to be valid on that edge. done is a
//   single-cycle pulse and diff/borrow_out/overflow are valid while it is
//   high (they stay held afterwards). state is a debug view of the FSM.
interface serial_subtractor_if
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             signed_mode;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    state_t           state;

    modport master (
        output start, a, b, borrow_in, signed_mode,
        input  ready, busy, done, diff, borrow_out, overflow, state
    );

    modport slave (
        input  start, a, b, borrow_in, signed_mode,
        output ready, busy, done, diff, borrow_out, overflow, state
    );
endinterface

// File: rtl/serial_subtractor_sub_slice.sv
// sub_slice: combinational DIGIT-bit subtractor cell with borrow chain.
// Ports:
//   x, y  : DIGIT-bit minuend / subtrahend slice
//   bin   : borrow into the slice
//   d     : DIGIT-bit difference
//   bout  : borrow out of the slice (1 when x < y + bin)
module sub_slice #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bin,
    output logic [DIGIT-1:0] d,
    output logic             bout
);
    // One extra bit catches the borrow: it is set exactly when the
    // zero-extended difference goes negative.
    logic [DIGIT:0] t;

    assign t    = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
    assign d    = t[DIGIT-1:0];
    assign bout = t[DIGIT];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle diff = a - b - borrow_in, DIGIT bits/clock.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_subtractor_if.slave (start/operands in, ready/busy/done,
//          diff/borrow_out/overflow and debug state out)
// One operation takes NSLICE RUN cycles plus one DONE cycle; a new start
// may be taken in the DONE cycle.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);
    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_subtractor: DIGIT must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
    logic             signed_q, borrow_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q, overflow_q;

    logic [DIGIT-1:0] slice_a, slice_b, slice_d;
    logic             slice_bo;
    logic             accept, last, ovf_next;
    int unsigned      base;

    sub_slice #(.DIGIT(DIGIT)) u_slice (
        .x    (slice_a),
        .y    (slice_b),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bo)
    );

    // Slice select and the result word as it will look after this slice.
    always_comb begin
        base     = int'(cnt) * DIGIT;
        slice_a  = a_q[base +: DIGIT];
        slice_b  = b_q[base +: DIGIT];
        res_next = res_q;
        res_next[base +: DIGIT] = slice_d;
        last     = (cnt == LAST);
        // Signed overflow: operands of different sign and the result sign
        // differs from the minuend.
        ovf_next = signed_q ? ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (res_next[WIDTH-1] ^ a_q[WIDTH-1]))
                            : slice_bo;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        bus.ready  = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                accept    = bus.start;
                if (bus.start) state_next = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.ready  = 1'b1;
                bus.done   = 1'b1;
                accept     = bus.start;
                state_next = bus.start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            signed_q     <= 1'b0;
            borrow_q     <= 1'b0;
            cnt          <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.borrow_in;
            signed_q <= bus.signed_mode;
            cnt      <= '0;
        end else if (state == RUN) begin
            res_q    <= res_next;
            borrow_q <= slice_bo;
            cnt      <= cnt + 1'b1;
            // Visible results change only on the edge that enters DONE.
            if (last) begin
                diff_q       <= res_next;
                borrow_out_q <= slice_bo;
                overflow_q   <= ovf_next;
            end
        end
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
    assign bus.overflow   = overflow_q;
    assign bus.state      = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed steps on a DIGIT=2 instance,
// then a random sweep driving DIGIT=1,2,4,8 instances in lockstep.
module tb_serial_subtractor;
    import arith_pkg::*;

    localparam int W = 8;
    typedef logic [W+1:0] res_t;   // {overflow, borrow_out, diff}

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic         sm;
        res_t         exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) if1 ();
    serial_subtractor_if #(.WIDTH(W)) if2 ();
    serial_subtractor_if #(.WIDTH(W)) if4 ();
    serial_subtractor_if #(.WIDTH(W)) if8 ();

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    serial_subtractor #(.WIDTH(W), .DIGIT(2)) u_d2 (.clk(clk), .rst(rst), .bus(if2));
    serial_subtractor #(.WIDTH(W), .DIGIT(4)) u_d4 (.clk(clk), .rst(rst), .bus(if4));
    serial_subtractor #(.WIDTH(W), .DIGIT(8)) u_d8 (.clk(clk), .rst(rst), .bus(if8));

    // ---------------- scoreboard ----------------
    res_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Hand-derived expectations for the directed cases.
    vec_t vecs[6] = '{
        '{8'h5A, 8'h3C, 1'b0, 1'b0, 10'h01E},
        '{8'h00, 8'h01, 1'b0, 1'b0, 10'h3FF},
        '{8'h00, 8'h01, 1'b0, 1'b1, 10'h1FF},
        '{8'h80, 8'h01, 1'b0, 1'b1, 10'h27F},
        '{8'h7F, 8'hFF, 1'b0, 1'b1, 10'h380},
        '{8'h10, 8'h0F, 1'b1, 1'b0, 10'h000}
    };

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: W+1-bit subtraction, overflow per mode.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, input logic sm);
        logic [W:0] t;
        logic       ovf;
        t   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        ovf = sm ? ((a[W-1] != b[W-1]) && (t[W-1] != a[W-1])) : t[W];
        return {ovf, t};
    endfunction

    // ---------------- driver tasks ----------------
    // Called #1 after an edge with the DUT ready; returns #1 after the
    // accepting edge (first RUN cycle).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic bin, input logic sm);
        if2.start       = 1'b1;
        if2.a           = a;
        if2.b           = b;
        if2.borrow_in   = bin;
        if2.signed_mode = sm;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
    endtask

    // Samples cycles k0.. after the accepting edge until done; latency is
    // the sample index at which done shows (5 for NSLICE=4).
    task automatic wait_result(input string tag, input int k0, output int busy_cnt);
        int   lat;
        bit   seen;
        res_t e;
        lat      = 0;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int k = k0; k <= 15; k++) begin
            if (k > k0) begin
                @(posedge clk);
                #1;
            end
            if (if2.busy === 1'b1) busy_cnt++;
            if (if2.done === 1'b1) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " latency"}, lat, 5);
            check({tag, " diff"}, if2.diff, e[W-1:0]);
            check({tag, " borrow_out"}, if2.borrow_out, e[W]);
            check({tag, " overflow"}, if2.overflow, e[W+1]);
            check({tag, " ready in done"}, if2.ready, 1'b1);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (if2.done === 1'b1) cnt++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   bc;
        int   nd;
        res_t first_res;
        int   nsl[4];
        logic [3:0] dn;
        bit   seen[4];
        int   lat[4];
        res_t got[4];
        logic [W-1:0] ra, rb;
        logic rbin, rsm;
        res_t e;

        nsl = '{8, 4, 2, 1};
        for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0;
            lat[i]  = 0;
            got[i]  = '0;
        end
        {if1.start, if2.start, if4.start, if8.start} = 4'b0;
        {if1.a, if1.b, if1.borrow_in, if1.signed_mode} = '0;
        {if2.a, if2.b, if2.borrow_in, if2.signed_mode} = '0;
        {if4.a, if4.b, if4.borrow_in, if4.signed_mode} = '0;
        {if8.a, if8.b, if8.borrow_in, if8.signed_mode} = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset diff", if2.diff, 0);
        check("reset borrow_out", if2.borrow_out, 0);
        check("reset overflow", if2.overflow, 0);
        check("reset done", if2.done, 0);
        check("reset busy", if2.busy, 0);
        check("reset ready", if2.ready, 1);
        check("reset state", if2.state, IDLE);

        // Directed operand table.
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].sm);
            wait_result($sformatf("vec%0d", i), 1, bc);
            if (i == 0) check("vec0 busy cycles", bc, 4);
            @(posedge clk);
            #1;
        end

        // Start pulsed mid-RUN must be ignored.
        exp_q.push_back(10'h022);
        start_op(8'h33, 8'h11, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        if2.start = 1'b1;
        if2.a     = 8'hFF;
        if2.b     = 8'h00;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
        wait_result("midrun", 3, bc);
        count_dones(8, nd);
        check("midrun no extra done", nd, 0);

        // Back-to-back: start taken in the DONE cycle.
        first_res = model(8'hC3, 8'h5A, 1'b1, 1'b1);
        exp_q.push_back(first_res);
        start_op(8'hC3, 8'h5A, 1'b1, 1'b1);
        wait_result("b2b first", 1, bc);
        exp_q.push_back(10'h3FF);
        start_op(8'h00, 8'h01, 1'b0, 1'b0);
        check("b2b diff held in run", if2.diff, first_res[W-1:0]);
        check("b2b busy after accept", if2.busy, 1);
        wait_result("b2b second", 1, bc);

        // Reset in the second RUN cycle abandons the operation.
        @(posedge clk);
        #1;
        start_op(8'h44, 8'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midreset diff", if2.diff, 0);
        check("midreset borrow_out", if2.borrow_out, 0);
        check("midreset overflow", if2.overflow, 0);
        check("midreset ready", if2.ready, 1);
        check("midreset busy", if2.busy, 0);
        check("midreset done", if2.done, 0);
        count_dones(8, nd);
        check("midreset no done", nd, 0);
        exp_q.push_back(model(8'h9C, 8'h2B, 1'b1, 1'b0));
        start_op(8'h9C, 8'h2B, 1'b1, 1'b0);
        wait_result("after reset", 1, bc);
        @(posedge clk);
        #1;

        // Random sweep across all four DIGIT configurations in lockstep.
        for (int n = 0; n < 1000; n++) begin
            ra   = W'($urandom_range(0, (1 << W) - 1));
            rb   = W'($urandom_range(0, (1 << W) - 1));
            rbin = 1'($urandom_range(0, 1));
            rsm  = 1'($urandom_range(0, 1));
            exp_q.push_back(model(ra, rb, rbin, rsm));
            if1.a = ra; if1.b = rb; if1.borrow_in = rbin; if1.signed_mode = rsm;
            if2.a = ra; if2.b = rb; if2.borrow_in = rbin; if2.signed_mode = rsm;
            if4.a = ra; if4.b = rb; if4.borrow_in = rbin; if4.signed_mode = rsm;
            if8.a = ra; if8.b = rb; if8.borrow_in = rbin; if8.signed_mode = rsm;
            {if1.start, if2.start, if4.start, if8.start} = 4'hF;
            @(posedge clk);
            #1;
            {if1.start, if2.start, if4.start, if8.start} = 4'h0;
            for (int j = 0; j < 4; j++) seen[j] = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                if (k > 1) begin
                    @(posedge clk);
                    #1;
                end
                dn = {if1.done, if2.done, if4.done, if8.done};
                if (dn[3] === 1'b1 && !seen[0]) begin seen[0] = 1; lat[0] = k; got[0] = {if1.overflow, if1.borrow_out, if1.diff}; end
                if (dn[2] === 1'b1 && !seen[1]) begin seen[1] = 1; lat[1] = k; got[1] = {if2.overflow, if2.borrow_out, if2.diff}; end
                if (dn[1] === 1'b1 && !seen[2]) begin seen[2] = 1; lat[2] = k; got[2] = {if4.overflow, if4.borrow_out, if4.diff}; end
                if (dn[0] === 1'b1 && !seen[3]) begin seen[3] = 1; lat[3] = k; got[3] = {if8.overflow, if8.borrow_out, if8.diff}; end
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            for (int j = 0; j < 4; j++) begin
                check($sformatf("sweep nslice%0d op%0d done seen", nsl[j], n), 32'(seen[j]), 32'd1);
                check($sformatf("sweep nslice%0d op%0d latency", nsl[j], n), lat[j], nsl[j] + 1);
                check($sformatf("sweep nslice%0d op%0d a=%0h b=%0h bin=%0d sm=%0d result",
                                nsl[j], n, ra, rb, rbin, rsm), 32'(got[j]), 32'(e));
            end
        end

        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
